// File: rtl/conv1_layer1_out_fea.sv
// conv1 layer1 dense output feature buffer: captures one frame of result
// words from the dense multiply stage, then serves it to the next layer
// through the need_data / data_v request protocol.
module conv1_layer1_out_fea #(
    parameter int unsigned DATA_W = 400,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mult_res_v,
    input  logic [DATA_W-1:0] mult_res,
    input  logic              need_data,
    output logic              data_v,
    output logic [DATA_W-1:0] out_fea,
    output logic              frame_full,
    output logic              frame_done,
    output logic              overflow
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic wr_en_c;
    logic rd_en_c;

    // Writes only land while filling; reads only while draining.
    assign wr_en_c = (state == FILL)  && mult_res_v;
    assign rd_en_c = (state == DRAIN) && need_data;

    // Frame memory write port (contents intentionally not reset).
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_ptr] <= mult_res;
        end
    end

    // Registered read port; out_fea holds between served words.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_fea <= '0;
        end else if (rd_en_c) begin
            out_fea <= mem[rd_ptr];
        end
    end

    // Frame control FSM with registered status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            data_v     <= 1'b0;
            frame_full <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            data_v     <= 1'b0;
            frame_full <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    // start wins over a same-cycle stray word, so its overflow is cleared
                    if (start) begin
                        wr_ptr   <= '0;
                        rd_ptr   <= '0;
                        overflow <= 1'b0;
                        state    <= FILL;
                    end else if (mult_res_v) begin
                        overflow <= 1'b1;
                    end
                end
                FILL: begin
                    if (mult_res_v) begin
                        if (wr_ptr == LAST_ADDR) begin
                            wr_ptr     <= '0;
                            frame_full <= 1'b1;
                            state      <= DRAIN;
                        end else begin
                            wr_ptr <= wr_ptr + ADDR_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (mult_res_v) begin
                        overflow <= 1'b1;
                    end
                    if (need_data) begin
                        data_v <= 1'b1;
                        rd_ptr <= rd_ptr + ADDR_W'(1);
                        if (rd_ptr == LAST_ADDR) begin
                            frame_done <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv1_layer1_out_fea.sv
// Scoreboard bench for conv1_layer1_out_fea: each accepted request pushes
// the expected word, last flag and arrival cycle; a negedge monitor pops
// and compares whenever data_v is seen.
module tb_conv1_layer1_out_fea;

    localparam int unsigned DATA_W = 400;
    localparam int unsigned DEPTH  = 64;
    localparam int unsigned ADDR_W = 6;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
        int                cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              mult_res_v;
    logic [DATA_W-1:0] mult_res;
    logic              need_data;
    logic              data_v;
    logic [DATA_W-1:0] out_fea;
    logic              frame_full;
    logic              frame_done;
    logic              overflow;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   mon_en   = 1'b0;
    exp_t sb [$];
    exp_t e;
    logic [DATA_W-1:0] exp_mem [DEPTH];

    conv1_layer1_out_fea #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mult_res_v(mult_res_v),
        .mult_res  (mult_res),
        .need_data (need_data),
        .data_v    (data_v),
        .out_fea   (out_fea),
        .frame_full(frame_full),
        .frame_done(frame_done),
        .overflow  (overflow)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // cycle counter used for latency checks
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (mon_en) begin
            if (data_v === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_data_v cyc=%0d got data_v=1 out_fea=%h required no data_v", cyc, out_fea);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (out_fea !== e.data) begin
                        failures++;
                        $display("FAIL out_fea cyc=%0d got=%h required=%h", cyc, out_fea, e.data);
                    end
                    checks++;
                    if (frame_done !== e.last) begin
                        failures++;
                        $display("FAIL frame_done_with_word cyc=%0d got=%b required=%b", cyc, frame_done, e.last);
                    end
                    checks++;
                    if (cyc != e.cyc) begin
                        failures++;
                        $display("FAIL read_latency got_cyc=%0d required_cyc=%0d", cyc, e.cyc);
                    end
                end
            end else begin
                checks++;
                if (data_v !== 1'b0 || frame_done !== 1'b0) begin
                    failures++;
                    $display("FAIL idle_outputs cyc=%0d got data_v=%b frame_done=%b required 0/0", cyc, data_v, frame_done);
                end
            end
        end
    end

    // absolute run bound
    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic write_word(input logic [DATA_W-1:0] w);
        mult_res_v = 1'b1;
        mult_res   = w;
        step();
        mult_res_v = 1'b0;
    endtask

    task automatic request(input logic [DATA_W-1:0] w, input logic last);
        need_data = 1'b1;
        sb.push_back('{data: w, last: last, cyc: cyc + 1});
        step();
        need_data = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (sb.size() > 0 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got pending=%0d required 0", sb.size());
            sb.delete();
        end
    endtask

    // write exp_mem as one frame; optional stray start before word start_at
    task automatic fill_frame(input bit gapped, input int start_at);
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (gapped) repeat ($urandom_range(0, 3)) step();
            if (k == start_at) start_frame();
            write_word(exp_mem[k]);
            checks++;
            if (frame_full !== (k == int'(DEPTH) - 1)) begin
                failures++;
                $display("FAIL frame_full word=%0d got=%b required=%b", k, frame_full, (k == int'(DEPTH) - 1));
            end
        end
    endtask

    task automatic drain_frame(input bit gapped);
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (gapped) repeat ($urandom_range(0, 3)) step();
            request(exp_mem[k], k == int'(DEPTH) - 1);
        end
        wait_empty();
    endtask

    task automatic load_counting(input int base);
        for (int k = 0; k < int'(DEPTH); k++) exp_mem[k] = {25{16'(base + k)}};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if (data_v !== 1'b0 || out_fea !== '0 || frame_full !== 1'b0 ||
            frame_done !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_values got dv=%b ff=%b fd=%b ov=%b out=%h required all 0",
                     data_v, frame_full, frame_done, overflow, out_fea);
        end
        mon_en    = 1'b1;
        need_data = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (data_v !== 1'b0 || out_fea !== '0) begin
                failures++;
                $display("FAIL idle_need_data i=%0d got dv=%b out=%h required 0", i, data_v, out_fea);
            end
        end
        need_data = 1'b0;
    endtask

    task automatic test_full_frame();
        load_counting(0);
        start_frame();
        fill_frame(1'b0, -1);
        drain_frame(1'b0);
    endtask

    task automatic test_gapped();
        logic [415:0] tmp;
        for (int k = 0; k < int'(DEPTH); k++) begin
            for (int j = 0; j < 13; j++) tmp[j*32 +: 32] = $urandom();
            exp_mem[k] = tmp[DATA_W-1:0];
        end
        start_frame();
        fill_frame(1'b1, -1);
        drain_frame(1'b1);
    endtask

    task automatic test_overflow();
        load_counting(100);
        start_frame();
        fill_frame(1'b0, -1);
        // stray word on the edge right after the frame completes
        write_word({25{16'hDEAD}});
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_set got=%b required=1", overflow);
        end
        drain_frame(1'b0);
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_held got=%b required=1", overflow);
        end
        // start and a stray word together: word dropped, overflow cleared
        start      = 1'b1;
        mult_res_v = 1'b1;
        mult_res   = {25{16'hBEEF}};
        step();
        start      = 1'b0;
        mult_res_v = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL overflow_cleared_by_start got=%b required=0", overflow);
        end
        load_counting(200);
        fill_frame(1'b0, -1);
        drain_frame(1'b0);
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL overflow_stays_clear got=%b required=0", overflow);
        end
    endtask

    task automatic test_ignored_start();
        load_counting(300);
        start_frame();
        fill_frame(1'b0, 30);
        drain_frame(1'b0);
    endtask

    task automatic test_reset_mid_drain();
        load_counting(400);
        start_frame();
        fill_frame(1'b0, -1);
        for (int k = 0; k < 20; k++) request(exp_mem[k], 1'b0);
        // reset together with a request: that read must never appear
        rst       = 1'b1;
        need_data = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (data_v !== 1'b0 || out_fea !== '0) begin
            failures++;
            $display("FAIL reset_mid_drain got dv=%b out=%h required 0", data_v, out_fea);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (data_v !== 1'b0) begin
                failures++;
                $display("FAIL post_reset_need_data i=%0d got=%b required=0", i, data_v);
            end
        end
        need_data = 1'b0;
        wait_empty();
        load_counting(500);
        start_frame();
        fill_frame(1'b0, -1);
        drain_frame(1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        mult_res_v = 1'b0;
        mult_res   = '0;
        need_data  = 1'b0;
        test_reset();
        test_full_frame();
        test_gapped();
        test_overflow();
        test_ignored_start();
        test_reset_mid_drain();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
